// File: rtl/arrow_hit_judge.sv
// Per-lane hit judge: counts target/note mask overlap each frame and grades button presses.
// Optional hit-flash mask is built only when ARROW_HIT_FLASH_EN is defined.
module arrow_hit_judge #(
  parameter int H_LAST       = 639,
  parameter int V_LAST       = 479,
  parameter int PERFECT_TH   = 400,
  parameter int GOOD_TH      = 100,
  parameter int PERFECT_PTS  = 100,
  parameter int GOOD_PTS     = 50,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_clk,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        target_px,
  input  logic        note_px,
  input  logic        btn,
  output logic        judge_valid,
  output logic [1:0]  judge,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [11:0] overlap_last,
  output logic        flash_px
);

  localparam logic [1:0] WAIT_NOTE = 2'd0;
  localparam logic [1:0] IN_WINDOW = 2'd1;
  localparam logic [1:0] JUDGED    = 2'd2;

  localparam logic [1:0] J_NONE    = 2'd0;
  localparam logic [1:0] J_MISS    = 2'd1;
  localparam logic [1:0] J_GOOD    = 2'd2;
  localparam logic [1:0] J_PERFECT = 2'd3;

  localparam logic [9:0]  X_MAX  = 10'(H_LAST);
  localparam logic [9:0]  Y_MAX  = 10'(V_LAST);
  localparam logic [11:0] P_TH   = 12'(PERFECT_TH);
  localparam logic [11:0] G_TH   = 12'(GOOD_TH);
  localparam logic [16:0] P_PTS  = 17'(PERFECT_PTS);
  localparam logic [16:0] G_PTS  = 17'(GOOD_PTS);

  // two sync flops plus one history flop for edge detect
  logic [2:0] btn_pipe;
  logic       press;

  always_ff @(posedge clk) begin
    if (rst) btn_pipe <= '0;
    else     btn_pipe <= {btn_pipe[1:0], btn};
  end

  assign press = btn_pipe[1] & ~btn_pipe[2];

  logic        hit_px, fe;
  logic [11:0] ovl_cnt, ovl_next;

  assign hit_px   = pix_clk && target_px && note_px && (x <= X_MAX) && (y <= Y_MAX);
  assign fe       = pix_clk && (x == X_MAX) && (y == Y_MAX);
  assign ovl_next = (hit_px && ovl_cnt != 12'hFFF) ? ovl_cnt + 12'd1 : ovl_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovl_cnt      <= '0;
      overlap_last <= '0;
    end else if (fe) begin
      ovl_cnt      <= '0;
      overlap_last <= ovl_next;
    end else begin
      ovl_cnt      <= ovl_next;
    end
  end

  logic [1:0] state, state_nxt;
  logic [1:0] jcode;
  logic [1:0] grade;

  assign grade = (overlap_last >= P_TH) ? J_PERFECT :
                 (overlap_last >= G_TH) ? J_GOOD : J_MISS;

  // A press in WAIT_NOTE has no transition of its own, so a frame end on the
  // same clk may still open the window; in IN_WINDOW the press always wins.
  always_comb begin
    state_nxt = state;
    jcode     = J_NONE;
    case (state)
      WAIT_NOTE: begin
        if (press) jcode = J_MISS;
        if (fe && ovl_next != '0) state_nxt = IN_WINDOW;
      end
      IN_WINDOW: begin
        if (press) begin
          jcode     = grade;
          state_nxt = JUDGED;
        end else if (fe && ovl_next == '0) begin
          jcode     = J_MISS;
          state_nxt = WAIT_NOTE;
        end
      end
      JUDGED: begin
        if (fe && ovl_next == '0) state_nxt = WAIT_NOTE;
      end
      default: state_nxt = WAIT_NOTE;
    endcase
  end

  logic        is_hit;
  logic [16:0] score_sum;

  assign is_hit    = jcode[1];
  assign score_sum = {1'b0, score} + ((jcode == J_PERFECT) ? P_PTS : G_PTS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_NOTE;
      judge_valid <= 1'b0;
      judge       <= J_NONE;
      score       <= '0;
      combo       <= '0;
    end else begin
      state       <= state_nxt;
      judge_valid <= (jcode != J_NONE);
      if (jcode != J_NONE) judge <= jcode;
      if (is_hit) begin
        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (combo != 8'hFF) combo <= combo + 8'd1;
      end else if (jcode == J_MISS) begin
        combo <= '0;
      end
    end
  end

`ifdef ARROW_HIT_FLASH_EN
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  logic [FW-1:0] flash_cnt;

  always_ff @(posedge clk) begin
    if (rst)                          flash_cnt <= '0;
    else if (is_hit)                  flash_cnt <= FW'(FLASH_FRAMES);
    else if (fe && flash_cnt != '0)   flash_cnt <= flash_cnt - 1'b1;
  end

  assign flash_px = target_px && (flash_cnt != '0);
`else
  localparam int unused_flash_frames = FLASH_FRAMES;
  assign flash_px = 1'b0;
`endif

endmodule

// File: tb/tb_arrow_hit_judge.sv
// Randomized + directed bench for arrow_hit_judge with a frame-level reference model
// and a scoreboard monitor for judgements (thresholds scaled down to keep frames short).
module tb_arrow_hit_judge;
  localparam int PT = 40, GT = 12, PP = 100, GP = 50, FF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1, pix_clk = 1'b0, target_px = 1'b0, note_px = 1'b0, btn = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        judge_valid, flash_px;
  logic [1:0]  judge;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [11:0] overlap_last;

  always #5 clk = ~clk;

  arrow_hit_judge #(
    .H_LAST(639), .V_LAST(479), .PERFECT_TH(PT), .GOOD_TH(GT),
    .PERFECT_PTS(PP), .GOOD_PTS(GP), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk), .rst(rst), .pix_clk(pix_clk), .x(x), .y(y),
    .target_px(target_px), .note_px(note_px), .btn(btn),
    .judge_valid(judge_valid), .judge(judge), .score(score), .combo(combo),
    .overlap_last(overlap_last), .flash_px(flash_px)
  );

  typedef struct { int cyc; int j; int score; int combo; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // reference model: frame-level view of the lane
  localparam int P_WAIT = 0, P_OPEN = 1, P_DONE = 2;
  int m_cnt, m_ol, m_phase, m_score, m_combo, m_flash;
  bit bh[3];

  function automatic void model_reset();
    m_cnt = 0; m_ol = 0; m_phase = P_WAIT; m_score = 0; m_combo = 0; m_flash = 0;
    bh[0] = 0; bh[1] = 0; bh[2] = 0;
  endfunction

  function automatic int grade_of(int ol);
    if (ol >= PT) return 3;
    if (ol >= GT) return 2;
    return 1;
  endfunction

  task automatic step(input bit pc, input int xx, input int yy, input bit t,
                      input bit n, input bit b, input bit r);
    bit press, fe, fexp, acted;
    int newc, j;
    exp_t e;
    pix_clk = pc; x = xx[9:0]; y = yy[9:0]; target_px = t; note_px = n; btn = b; rst = r;
`ifdef ARROW_HIT_FLASH_EN
    fexp = t && (m_flash != 0);
`else
    fexp = 1'b0;
`endif
    fe = pc && xx == 639 && yy == 479;
    if (r) model_reset();
    else begin
      press = bh[1] && !bh[2];
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = b;
      newc = m_cnt + ((pc && t && n && xx <= 639 && yy <= 479) ? 1 : 0);
      if (newc > 4095) newc = 4095;
      j = 0; acted = 0;
      if (press && m_phase == P_WAIT) j = 1;
      else if (press && m_phase == P_OPEN) begin
        j = grade_of(m_ol); m_phase = P_DONE; acted = 1;
      end
      if (fe) begin
        m_ol = newc; m_cnt = 0;
        if (!acted) begin
          if (m_phase == P_WAIT && newc > 0) m_phase = P_OPEN;
          else if (m_phase == P_OPEN && newc == 0) begin j = 1; m_phase = P_WAIT; end
          else if (m_phase == P_DONE && newc == 0) m_phase = P_WAIT;
        end
      end else m_cnt = newc;
      if (j >= 2) begin
        m_score = m_score + ((j == 3) ? PP : GP);
        if (m_score > 65535) m_score = 65535;
        if (m_combo < 255) m_combo++;
        m_flash = FF;
      end else begin
        if (j == 1) m_combo = 0;
        if (fe && m_flash > 0) m_flash--;
      end
      if (j != 0) begin
        e.cyc = cyc; e.j = j; e.score = m_score; e.combo = m_combo;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    chk("flash_px", int'(flash_px), int'(fexp));
    @(posedge clk); #1;
    cyc++;
    if (!r && fe) chk("overlap_last", int'(overlap_last), m_ol);
  endtask

  // novl counted pixels, two out-of-range overlap pixels, two idle pixels, then
  // the frame-end pixel (which also overlaps when novl>0); btn rises at index pat.
  task automatic frame(input int novl, input int pat);
    int L = novl + 5;
    bit b;
    for (int i = 0; i < L; i++) begin
      b = (pat >= 0 && i >= pat && i < pat + 4);
      if (i < novl)
        step(1, $urandom_range(0, 639), $urandom_range(0, 478), 1, 1, b, 0);
      else if (i == novl)
        step(1, $urandom_range(640, 1023), $urandom_range(0, 479), 1, 1, b, 0);
      else if (i == novl + 1)
        step(1, $urandom_range(0, 639), $urandom_range(480, 1023), 1, 1, b, 0);
      else if (i < L - 1)
        step(1, $urandom_range(0, 639), $urandom_range(0, 478), 1, 0, b, 0);
      else
        step(1, 639, 479, 1, novl > 0, b, 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (judge_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_judge: got judge %0d with nothing expected (cycle %0d)", judge, cyc);
      end else begin
        e = sb.pop_front();
        chk("judge_cycle", cyc - 1, e.cyc);
        chk("judge", int'(judge), e.j);
        chk("score", int'(score), e.score);
        chk("combo", int'(combo), e.combo);
      end
    end
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    bit rb, rr;
    int rx, ry;
    @(posedge clk); #1;
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("rst_judge_valid", int'(judge_valid), 0);
    chk("rst_judge", int'(judge), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_combo", int'(combo), 0);
    chk("rst_overlap_last", int'(overlap_last), 0);

    frame(0, -1);
    chk("empty_frame_score", int'(score), 0);
    chk("empty_frame_combo", int'(combo), 0);

    frame(45, -1); frame(45, 1); frame(0, 1);       // PERFECT, then ignored press
    chk("perfect_score", int'(score), 100);
    chk("perfect_combo", int'(combo), 1);
    frame(15, -1); frame(0, 1);                     // GOOD
    chk("good_score", int'(score), 150);
    frame(5, -1); frame(0, 1);                      // MISS on small overlap
    chk("miss_combo", int'(combo), 0);
    frame(50, -1); frame(0, -1);                    // auto MISS
    frame(42, -1); frame(0, 2); frame(0, -1);       // press lands on frame end
    chk("fe_press_score", int'(score), 250);
    frame(4100, -1);
    chk("overlap_saturated", int'(overlap_last), 4095);
    frame(0, -1);
    frame(30, -1);
    for (int i = 0; i < 20; i++) step(1, i, 3, 1, 1, 0, 0);
    step(1, 5, 5, 1, 1, 0, 1);                      // reset mid-frame
    frame(0, 1);
    frame(45, -1); frame(0, 1);
    for (int k = 0; k < 10; k++) frame(3, -1);      // hit-flash window

    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 14) == 0) rb = ~rb;
      if ($urandom_range(0, 39) == 0) begin rx = 639; ry = 479; end
      else begin rx = $urandom_range(0, 700); ry = $urandom_range(0, 500); end
      step($urandom_range(0, 3) != 0, rx, ry, $urandom_range(0, 1), $urandom_range(0, 1), rb, rr);
    end

    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 260; k++) begin frame(15, -1); frame(0, 1); end
    chk("combo_saturated", int'(combo), 255);
    for (int k = 0; k < 660; k++) begin frame(45, -1); frame(0, 1); end
    chk("score_saturated", int'(score), 65535);
    chk("combo_held", int'(combo), 255);

    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arrow_hit_judge.md
Name: arrow_hit_judge

Overview:
- Consumes the per-pixel target-arrow mask and the scrolling-note mask from the VGA pixel stream.
- Measures their overlap once per frame, then judges the player's button press as PERFECT, GOOD or MISS.
- Maintains score and combo counters for the HUD.
- Sits directly downstream of the target-arrow renderer and the note renderer for one lane.

Parameters:
- H_LAST, 639, last visible x coordinate.
- V_LAST, 479, last visible y coordinate.
- PERFECT_TH, 400, minimum overlap pixel count for a PERFECT.
- GOOD_TH, 100, minimum overlap pixel count for a GOOD (GOOD_TH < PERFECT_TH).
- PERFECT_PTS, 100, score increment for a PERFECT.
- GOOD_PTS, 50, score increment for a GOOD.
- FLASH_FRAMES, 8, frames of hit flash (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Interface)
- pix_clk  in  1  pixel enable, one clk wide; x, y, target_px, note_px are valid when high
- x  in  10  current pixel column
- y  in  10  current pixel row
- target_px  in  1  target-arrow mask bit for (x,y)
- note_px  in  1  scrolling-note mask bit for (x,y)
- btn  in  1  raw asynchronous lane button, active-high
- judge_valid  out  1  one-clk pulse when a judgement is issued
- judge  out  2  0=NONE, 1=MISS, 2=GOOD, 3=PERFECT; holds the last judgement
- score  out  16  accumulated score, saturating
- combo  out  8  consecutive PERFECT/GOOD count, saturating
- overlap_last  out  12  overlap count of the last completed frame
- flash_px  out  1  hit-flash mask (optional feature)

Interface:
- Reset rst is synchronous and active-high; clock is clk.
- All state updates on posedge clk.

Behaviour:
- Reset values: judge_valid=0, judge=0, score=0, combo=0, overlap_last=0, flash_px=0. Internal overlap counter=0, state=WAIT_NOTE, sync flops=0, flash counter=0.
- btn path: two-flop synchronizer, then rising-edge detect, giving press (one clk). Press latency is 3 clk from the btn rise.
- Overlap counter (12 bit):
  - Increments on each clk where pix_clk && target_px && note_px && x<=H_LAST && y<=V_LAST.
  - Saturates at 4095.
- Frame end (fe) occurs on the clk where pix_clk && x==H_LAST && y==V_LAST.
  - The counting term for that pixel is included.
  - overlap_last <= final count, and the counter clears to 0 on the same clk.
- FSM states and transitions:
  - WAIT_NOTE:
    - On press: issue MISS.
    - On fe with new count>0: go to IN_WINDOW.
  - IN_WINDOW:
    - On press: judge using the current (pre-update) overlap_last. overlap_last>=PERFECT_TH gives PERFECT; >=GOOD_TH gives GOOD; otherwise MISS. Then go to JUDGED.
    - On fe with new count==0 and no press: auto MISS, go to WAIT_NOTE.
  - JUDGED:
    - Presses are ignored (no judge_valid).
    - On fe with new count==0: go to WAIT_NOTE.
- Simultaneous press and fe on the same clk:
  - The press is judged against the old overlap_last and its transition wins.
  - overlap_last still updates.
  - Auto MISS is suppressed on that clk.
- Judgement issue:
  - judge_valid=1 for exactly one clk; judge is registered on the same edge.
  - PERFECT: score += PERFECT_PTS, combo += 1.
  - GOOD: score += GOOD_PTS, combo += 1.
  - MISS: combo <= 0, score unchanged.
  - score saturates at 65535; combo saturates at 255.
- Reset asserted mid-frame or mid-judgement returns everything to reset values on the next edge. The partial-frame count is discarded.

Optional Feature:
- Macro: ARROW_HIT_FLASH_EN.
- When defined:
  - A PERFECT or GOOD loads the flash counter with FLASH_FRAMES.
  - The counter decrements at each fe while nonzero.
  - flash_px = target_px && (flash counter != 0), combinational from inputs.
  - A new hit while flashing reloads the counter.
- When undefined: flash_px is tied to 0 and no counter is synthesized.

Test Plan:
- Reset, then a frame with note_px=0 everywhere -> overlap_last=0, state WAIT_NOTE, no judge_valid, score=0, combo=0.
- Frame with 450 overlapping pixels, then press in the next frame -> judge_valid pulse 3 clk after btn rise, judge=3, score=100, combo=1. A second press before an empty frame -> no pulse.
- Frame overlap 150 then press -> judge=2, score+=50. Frame overlap 50 then press -> judge=1, combo=0.
- Overlap 500 for one frame, then a frame with 0 and no press -> auto MISS pulse on that fe clk, combo reset, state WAIT_NOTE.
- btn rise timed so press lands on the fe clk, old overlap_last=420, new count 0 -> PERFECT issued, no auto MISS. Also: score preloaded near 65500 plus PERFECT -> 65535. Also: 256 consecutive GOODs -> combo=255.
- With ARROW_HIT_FLASH_EN: PERFECT -> flash_px follows target_px for exactly 8 fe events, then 0. Without the macro, flash_px stays 0 throughout.
